// File: rtl/round_scoreboard_if.sv
// round_scoreboard_if
// Bundles the event inputs and scoreboard outputs of round_scoreboard.
// Parameters must match those of the round_scoreboard instance it connects to.
//   master : drives hit/escape, observes the scoreboard (testbench / game logic)
//   slave  : the scoreboard itself
// Signals: hit, escape (event pulses); hit_mask, hits, misses, round,
//          round_done, game_over, score, bcd, bcd_valid, streak.
interface round_scoreboard_if #(
  parameter int BIRDS   = 10,
  parameter int DIGITS  = 4,
  parameter int SCORE_W = 14,
  parameter int ROUND_W = 4
);
  localparam int CW = $clog2(BIRDS + 1);

  logic                  hit;
  logic                  escape;
  logic [BIRDS-1:0]      hit_mask;
  logic [CW-1:0]         hits;
  logic [CW-1:0]         misses;
  logic [ROUND_W-1:0]    round;
  logic                  round_done;
  logic                  game_over;
  logic [SCORE_W-1:0]    score;
  logic [4*DIGITS-1:0]   bcd;
  logic                  bcd_valid;
  logic [3:0]            streak;

  modport master (
    output hit, escape,
    input  hit_mask, hits, misses, round, round_done, game_over,
           score, bcd, bcd_valid, streak
  );

  modport slave (
    input  hit, escape,
    output hit_mask, hits, misses, round, round_done, game_over,
           score, bcd, bcd_valid, streak
  );
endinterface

// File: rtl/round_scoreboard.sv
// round_scoreboard
// Per-round hit/escape scoreboard for a shooting game with a saturating
// binary score and a sequential double-dabble BCD converter.
// Ports: clk (rising edge), resetn (async, active-low),
//        bus (round_scoreboard_if.slave): hit/escape in, scoreboard out.
// Optional feature: define ROUND_SCOREBOARD_STREAK_BONUS_EN to enable the
// consecutive-hit streak counter and double points from the third hit on.
//
// state | meaning
// PLAY  | accepting hit/escape events for the current round
// EVAL  | one cycle: round complete, decide pass or fail
// OVER  | round failed, terminal until reset
module round_scoreboard #(
  parameter int BIRDS     = 10,
  parameter int PASS_HITS = 5,
  parameter int HIT_PTS   = 50,
  parameter int MISS_PTS  = 10,
  parameter int DIGITS    = 4,
  parameter int SCORE_W   = 14,
  parameter int ROUND_W   = 4
) (
  input  logic               clk,
  input  logic               resetn,
  round_scoreboard_if.slave  bus
);
  localparam int CW        = $clog2(BIRDS + 1);
  localparam int SCORE_MAX = 10**DIGITS - 1;
  localparam int BW        = 4 * DIGITS;
  localparam int KW        = $clog2(SCORE_W + 1);

  typedef enum logic [1:0] {PLAY, EVAL, OVER} state_t;
  state_t state, state_nxt;

  logic                armed;
  logic [BIRDS-1:0]    mask_q;
  logic [CW-1:0]       hits_q, misses_q, total_nxt;
  logic [ROUND_W-1:0]  round_q;
  logic                over_q;
  logic [SCORE_W-1:0]  score_q, score_nxt;
  logic                score_we;
  logic [3:0]          streak_q;
  logic                acc_hit, acc_esc, round_pass, round_done;
  int                  pts;

  // armed blocks events sampled on the first edge after reset release
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) armed <= 1'b0;
    else         armed <= 1'b1;

  assign acc_hit    = armed && (state == PLAY) && bus.hit;
  assign acc_esc    = armed && (state == PLAY) && bus.escape && !bus.hit;
  assign total_nxt  = hits_q + misses_q + CW'(1);
  assign round_pass = (state == EVAL) && (hits_q >= CW'(PASS_HITS));

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= PLAY;
    else         state <= state_nxt;

  always_comb begin
    state_nxt  = state;
    round_done = 1'b0;
    case (state)
      PLAY: if ((acc_hit || acc_esc) && (total_nxt == CW'(BIRDS))) state_nxt = EVAL;
      EVAL: begin
        if (round_pass) begin
          round_done = 1'b1;
          state_nxt  = PLAY;
        end else begin
          state_nxt  = OVER;
        end
      end
      OVER:    state_nxt = OVER;
      default: state_nxt = PLAY;
    endcase
  end

`ifdef ROUND_SCOREBOARD_STREAK_BONUS_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) streak_q <= 4'd0;
    else if (acc_hit) begin
      if (streak_q != 4'hF) streak_q <= streak_q + 4'd1;
    end else if (acc_esc || round_pass) begin
      streak_q <= 4'd0;
    end

  // streak_q counts hits before this one, so >= 2 means third or later
  assign pts = (streak_q >= 4'd2) ? 2 * HIT_PTS : HIT_PTS;
`else
  assign streak_q = 4'd0;
  assign pts      = HIT_PTS;
`endif

  always_comb begin
    score_nxt = score_q;
    if (acc_hit) begin
      if (int'(score_q) + pts > SCORE_MAX) score_nxt = SCORE_W'(SCORE_MAX);
      else                                 score_nxt = score_q + SCORE_W'(pts);
    end else if (acc_esc) begin
      if (int'(score_q) < MISS_PTS) score_nxt = '0;
      else                          score_nxt = score_q - SCORE_W'(MISS_PTS);
    end
  end

  assign score_we = (score_nxt != score_q);

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      score_q  <= '0;
      mask_q   <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      round_q  <= '0;
      over_q   <= 1'b0;
    end else begin
      score_q <= score_nxt;
      if (acc_hit) begin
        mask_q <= mask_q | (BIRDS'(1) << (hits_q + misses_q));
        hits_q <= hits_q + CW'(1);
      end else if (acc_esc) begin
        misses_q <= misses_q + CW'(1);
      end
      if (state == EVAL) begin
        if (round_pass) begin
          if (round_q != '1) round_q <= round_q + ROUND_W'(1);
          hits_q   <= '0;
          misses_q <= '0;
          mask_q   <= '0;
        end else begin
          over_q <= 1'b1;
        end
      end
    end

  // Double-dabble: load, SCORE_W shift cycles, then a commit cycle.
  // A score change at any point before commit marks the result stale.
  logic [SCORE_W-1:0] sr;
  logic [BW-1:0]      acc, acc_adj, bcd_q;
  logic [KW-1:0]      cnt;
  logic               busy, pend, valid_q;

  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < DIGITS; d++)
      if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sr      <= '0;
      acc     <= '0;
      bcd_q   <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      pend    <= 1'b0;
      valid_q <= 1'b1;
    end else begin
      if (!busy) begin
        if (pend) begin
          busy <= 1'b1;
          sr   <= score_q;
          acc  <= '0;
          cnt  <= KW'(SCORE_W);
          pend <= 1'b0;
        end
      end else if (cnt != '0) begin
        acc <= {acc_adj[BW-2:0], sr[SCORE_W-1]};
        sr  <= sr << 1;
        cnt <= cnt - KW'(1);
      end else begin
        busy <= 1'b0;
        if (!pend && !score_we) begin
          bcd_q   <= acc;
          valid_q <= 1'b1;
        end
      end
      // last so a change always wins over load/commit
      if (score_we) begin
        pend    <= 1'b1;
        valid_q <= 1'b0;
      end
    end

  assign bus.hit_mask   = mask_q;
  assign bus.hits       = hits_q;
  assign bus.misses     = misses_q;
  assign bus.round      = round_q;
  assign bus.round_done = round_done;
  assign bus.game_over  = over_q;
  assign bus.score      = score_q;
  assign bus.bcd        = bcd_q;
  assign bus.bcd_valid  = valid_q;
  assign bus.streak     = streak_q;
endmodule
